serial_magnitude_compare_ctrl: RTL

Sequencing controller that performs a WIDTH-bit unsigned magnitude comparison by stepping two latched operands MSB-first through a single internal one-bit comparator cell, one bit per clock. It scans only until the first differing bit, then reports a one-hot greater/equal/less result with a one-cycle done pulse. It sits between a requester issuing compare jobs and the shared one-bit comparator datapath, trading latency for area.

---
 rtl/serial_magnitude_compare_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/serial_magnitude_compare_ctrl.sv
// Serial MSB-first unsigned magnitude comparator controller: walks two latched
// operands through one shared 1-bit compare cell until the first differing bit.
`default_nettype none

module serial_magnitude_bit_cell (
   input  logic a_i,
   input  logic b_i,
   output logic gt_o,
   output logic eq_o,
   output logic lt_o
);
   assign gt_o = a_i & ~b_i;
   assign eq_o = ~(a_i ^ b_i);
   assign lt_o = ~a_i & b_i;
endmodule

module serial_magnitude_compare_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNTW  = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             gt_o,
   output logic             eq_o,
   output logic             lt_o,
   output logic [CNTW-1:0]  bits_scanned_o
);
   localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic              gt_q, gt_d;
   logic              eq_q, eq_d;
   logic              lt_q, lt_d;
   logic              done_q, done_d;
   logic [CNTW-1:0]   bits_q, bits_d;

   logic cell_gt, cell_eq, cell_lt;

   serial_magnitude_bit_cell u_cell (
      .a_i  (a_q[idx_q]),
      .b_i  (b_q[idx_q]),
      .gt_o (cell_gt),
      .eq_o (cell_eq),
      .lt_o (cell_lt)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      gt_d    = gt_q;
      eq_d    = eq_q;
      lt_d    = lt_q;
      bits_d  = bits_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               a_d     = a_i;
               b_d     = b_i;
               idx_d   = IDXW'(WIDTH - 1);
               cnt_d   = '0;
               gt_d    = 1'b0;
               eq_d    = 1'b0;
               lt_d    = 1'b0;
               bits_d  = '0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            // Abort wins over a decision landing in the same cycle.
            if (abort_i) begin
               state_d = IDLE;
            end else if (cell_gt) begin
               gt_d    = 1'b1;
               done_d  = 1'b1;
               bits_d  = cnt_q + CNTW'(1);
               state_d = IDLE;
            end else if (cell_lt) begin
               lt_d    = 1'b1;
               done_d  = 1'b1;
               bits_d  = cnt_q + CNTW'(1);
               state_d = IDLE;
            end else if (cell_eq && (idx_q == '0)) begin
               eq_d    = 1'b1;
               done_d  = 1'b1;
               bits_d  = CNTW'(WIDTH);
               state_d = IDLE;
            end else begin
               idx_d = idx_q - IDXW'(1);
               cnt_d = cnt_q + CNTW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         gt_q    <= 1'b0;
         eq_q    <= 1'b0;
         lt_q    <= 1'b0;
         done_q  <= 1'b0;
         bits_q  <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         gt_q    <= gt_d;
         eq_q    <= eq_d;
         lt_q    <= lt_d;
         done_q  <= done_d;
         bits_q  <= bits_d;
      end
   end

   assign busy_o         = (state_q == SCAN);
   assign done_o         = done_q;
   assign gt_o           = gt_q;
   assign eq_o           = eq_q;
   assign lt_o           = lt_q;
   assign bits_scanned_o = bits_q;

endmodule

`default_nettype wire
